// File: rtl/usadd_pkg.sv
// usadd_pkg
// Shared definitions for the unary scaled-add front end.
//   state_t    : bitstream generator FSM state (IDLE, RUN, LAST)
//   stream_len : stream length N = 2^bitwidth for a given operand width
package usadd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_LAST = 2'd2
   } state_t;

   function automatic int stream_len(input int bitwidth);
      return 1 << bitwidth;
   endfunction

endpackage

// File: rtl/sobolrng.sv
// sobolrng
// First-dimension Sobol sequence generator (Gray-code construction with
// direction numbers v_k = 2^(BITWIDTH-1-k)). Over 2^BITWIDTH enabled steps
// from a clear it visits every BITWIDTH-bit value exactly once:
// 0, 128, 192, 64, 96, 224, 160, 32, ... for BITWIDTH = 8.
//   iClk     : clock, rising edge
//   iRstN    : asynchronous active-low reset
//   iEn      : advance to the next sequence word
//   iClr     : synchronous restart at index 0 (word 0), priority over iEn
//   sobolseq : current Sobol word
module sobolrng #(
   parameter int BITWIDTH = 8
) (
   input  logic                iClk,
   input  logic                iRstN,
   input  logic                iEn,
   input  logic                iClr,
   output logic [BITWIDTH-1:0] sobolseq
);

   logic [BITWIDTH-1:0] idx_q;
   logic [BITWIDTH-1:0] seq_q;
   logic [BITWIDTH-1:0] dir_d;
   logic                found;

   // Direction number selected by the lowest zero bit of the current index.
   always_comb begin
      dir_d = '0;
      found = 1'b0;
      for (int k = 0; k < BITWIDTH; k++) begin
         if (!found && !idx_q[k]) begin
            dir_d[BITWIDTH-1-k] = 1'b1;
            found               = 1'b1;
         end
      end
   end

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         idx_q <= '0;
         seq_q <= '0;
      end else if (iClr) begin
         idx_q <= '0;
         seq_q <= '0;
      end else if (iEn) begin
         idx_q <= idx_q + BITWIDTH'(1);
         seq_q <= seq_q ^ dir_d;
      end
   end

   assign sobolseq = seq_q;

endmodule

// File: rtl/unary_ones_cnt.sv
// unary_ones_cnt
// Enable/clear counter that tallies the ones of a unary bitstream.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset, clears the count
//   clr_i  : synchronous clear, has priority over en_i
//   en_i   : increment by one this cycle
//   cnt_o  : current count (W bits)
module unary_ones_cnt #(
   parameter int W = 9
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/sobol_bsgen.sv
// sobol_bsgen
// Converts a BITWIDTH-bit unsigned operand into a 2^BITWIDTH-cycle unary
// bitstream by strict unsigned compare against the Sobol word from sobolrng,
// which this block drives through oRngEn / oRngClr.
//
// Optional feature: define USADD_ONES_CNT_EN to add the oOnes port and the
// ones counter behind it. Without the macro the port and counter are absent.
//
// Ports:
//   iClk      : clock, rising edge
//   iRstN     : asynchronous active-low reset
//   iEn       : stall control, low freezes RUN progress
//   iClr      : synchronous abort to IDLE (priority over everything else)
//   iValid    : operand valid
//   iData     : operand, represents iData/N
//   oReady    : operand accept, high only in IDLE
//   iRng      : Sobol word from sobolrng
//   oRngEn    : sobolrng enable
//   oRngClr   : sobolrng clear
//   oBit      : registered bitstream bit
//   oBitValid : oBit qualifier
//   oDone     : one-cycle pulse coinciding with the final stream bit
//   oDbgState : current FSM state
//   oOnes     : ones count of the completed stream (USADD_ONES_CNT_EN only)
//
// Handshake: an operand transfers on a rising edge where iValid && oReady
// and iClr is low; oReady is combinational from state and never depends on
// iValid. The stream then follows with no backpressure on the bit side.
module sobol_bsgen
   import usadd_pkg::*;
#(
   parameter int BITWIDTH = 8
) (
   input  logic                iClk,
   input  logic                iRstN,
   input  logic                iEn,
   input  logic                iClr,
   input  logic                iValid,
   input  logic [BITWIDTH-1:0] iData,
   output logic                oReady,
   input  logic [BITWIDTH-1:0] iRng,
   output logic                oRngEn,
   output logic                oRngClr,
   output logic                oBit,
   output logic                oBitValid,
   output logic                oDone,
   output state_t              oDbgState
`ifdef USADD_ONES_CNT_EN
   ,
   output logic [BITWIDTH:0]   oOnes
`endif
);

   localparam logic [BITWIDTH-1:0] CNT_LAST = BITWIDTH'(stream_len(BITWIDTH) - 1);

   state_t              state_q;
   logic [BITWIDTH-1:0] operand_q;
   logic [BITWIDTH-1:0] cnt_q;
   logic                bit_q;
   logic                bit_valid_q;
   logic                done_q;

   logic [BITWIDTH-1:0] cnt_d;
   logic                bit_d;

   always_comb begin
      cnt_d = cnt_q + BITWIDTH'(1);
      // Strict greater-than: operand 0 gives no ones, N-1 gives N-1 ones.
      bit_d = (operand_q > iRng);
   end

   // IDLE holds the RNG in clear so every stream starts at sequence index 0.
   assign oReady  = (state_q == ST_IDLE);
   assign oRngClr = (state_q == ST_IDLE);
   assign oRngEn  = (state_q == ST_RUN) && iEn;

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         state_q     <= ST_IDLE;
         operand_q   <= '0;
         cnt_q       <= '0;
         bit_q       <= 1'b0;
         bit_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else if (iClr) begin
         // Abort keeps the operand; the next accept overwrites it anyway.
         state_q     <= ST_IDLE;
         bit_q       <= 1'b0;
         bit_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               bit_valid_q <= 1'b0;
               done_q      <= 1'b0;
               if (iValid) begin
                  operand_q <= iData;
                  cnt_q     <= '0;
                  state_q   <= ST_RUN;
               end
            end
            ST_RUN: begin
               done_q <= 1'b0;
               if (iEn) begin
                  bit_q       <= bit_d;
                  bit_valid_q <= 1'b1;
                  cnt_q       <= cnt_d;
                  // Final bit is captured on this edge, so LAST presents it
                  // together with the done pulse.
                  if (cnt_q == CNT_LAST) begin
                     state_q <= ST_LAST;
                     done_q  <= 1'b1;
                  end
               end else begin
                  bit_valid_q <= 1'b0;
               end
            end
            ST_LAST: begin
               bit_valid_q <= 1'b0;
               done_q      <= 1'b0;
               state_q     <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign oBit      = bit_q;
   assign oBitValid = bit_valid_q;
   assign oDone     = done_q;
   assign oDbgState = state_q;

`ifdef USADD_ONES_CNT_EN
   logic ones_clr;
   logic ones_inc;

   // Counted at capture time so the total already includes the final bit
   // when oDone is presented.
   assign ones_clr = iClr || ((state_q == ST_IDLE) && iValid);
   assign ones_inc = (state_q == ST_RUN) && iEn && bit_d;

   unary_ones_cnt #(
      .W(BITWIDTH + 1)
   ) u_ones_cnt (
      .clk_i (iClk),
      .rst_ni(iRstN),
      .clr_i (ones_clr),
      .en_i  (ones_inc),
      .cnt_o (oOnes)
   );
`endif

endmodule

// File: tb/tb_sobol_bsgen.sv
// Bench for sobol_bsgen wired to sobolrng. Driver tasks issue operands and
// push the expected ones count and accept-to-done latency; a monitor on the
// falling edge pops and compares on every oDone.
module tb_sobol_bsgen;
   import usadd_pkg::*;

   localparam int BW = 8;
   localparam int N  = 256;

   logic          iClk;
   logic          iRstN;
   logic          iEn;
   logic          iClr;
   logic          iValid;
   logic [BW-1:0] iData;
   logic          oReady;
   logic [BW-1:0] rng;
   logic          rng_en;
   logic          rng_clr;
   logic          oBit;
   logic          oBitValid;
   logic          oDone;
   state_t        dbg_state;
`ifdef USADD_ONES_CNT_EN
   logic [BW:0]   ones;
`endif

   sobolrng #(.BITWIDTH(BW)) u_rng (
      .iClk    (iClk),
      .iRstN   (iRstN),
      .iEn     (rng_en),
      .iClr    (rng_clr),
      .sobolseq(rng)
   );

   sobol_bsgen #(.BITWIDTH(BW)) dut (
      .iClk     (iClk),
      .iRstN    (iRstN),
      .iEn      (iEn),
      .iClr     (iClr),
      .iValid   (iValid),
      .iData    (iData),
      .oReady   (oReady),
      .iRng     (rng),
      .oRngEn   (rng_en),
      .oRngClr  (rng_clr),
      .oBit     (oBit),
      .oBitValid(oBitValid),
      .oDone    (oDone),
      .oDbgState(dbg_state)
`ifdef USADD_ONES_CNT_EN
      ,
      .oOnes    (ones)
`endif
   );

   // ---------------- clock / reset ----------------
   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   int cyc = 0;
   always @(posedge iClk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   logic [BW:0] exp_q[$];
   int          exp_lat_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_pushed = 0;

   int          bits_seen = 0;
   int          ones_seen = 0;
   int          done_cnt  = 0;
   int          start_cyc = 0;
   int          done_cyc  = 0;
   int          last_gap  = -1;
   logic        chk_rng0  = 1'b0;
   logic        chk_ready = 1'b0;
   logic [3:0]  first_bits = 4'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge iClk) begin
      if (!iRstN) begin
         bits_seen = 0;
         ones_seen = 0;
         chk_rng0  = 1'b0;
         chk_ready = 1'b0;
      end else begin
         if (chk_rng0) begin
            check("rng_restart_idx0", 32'(rng), 32'd0);
            chk_rng0 = 1'b0;
         end
         if (chk_ready) begin
            check("ready_after_done", 32'(oReady), 32'd1);
            chk_ready = 1'b0;
         end
         if (oBitValid) begin
            if (bits_seen < 4) first_bits[bits_seen] = oBit;
            bits_seen++;
            ones_seen += int'(oBit);
         end
         if (oDone) begin
            check("done_with_valid", 32'(oBitValid), 32'd1);
            if (exp_q.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               logic [BW:0] e;
               int          el;
               e  = exp_q.pop_front();
               el = exp_lat_q.pop_front();
               check("stream_ones", 32'(ones_seen), 32'(e));
               check("stream_len", 32'(bits_seen), 32'(N));
               check("accept_to_done", 32'(cyc - start_cyc), 32'(el));
`ifdef USADD_ONES_CNT_EN
               check("oOnes", 32'(ones), 32'(e));
`endif
            end
            done_cnt++;
            done_cyc  = cyc;
            chk_ready = 1'b1;
         end
         if (oReady) begin
            bits_seen = 0;
            ones_seen = 0;
            if (iValid && !iClr) begin
               start_cyc = cyc + 1;
               last_gap  = cyc - done_cyc;
               chk_rng0  = 1'b1;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_accept();
      bit got = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge iClk);
         if (oReady) begin
            got = 1'b1;
            break;
         end
      end
      check("accept_timeout", 32'(got), 32'd1);
      @(posedge iClk);
      #1;
      iValid = 1'b0;
   endtask

   task automatic post(input logic [BW-1:0] d, input logic [BW:0] exp_ones, input int lat);
      exp_q.push_back(exp_ones);
      exp_lat_q.push_back(lat);
      n_pushed++;
      iData  = d;
      iValid = 1'b1;
   endtask

   task automatic send(input logic [BW-1:0] d, input logic [BW:0] exp_ones, input int lat);
      post(d, exp_ones, lat);
      wait_accept();
   endtask

   task automatic wait_bits(input int n);
      bit got = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge iClk);
         #1;
         if (bits_seen >= n) begin
            got = 1'b1;
            break;
         end
      end
      check("bits_timeout", 32'(got), 32'd1);
   endtask

   task automatic wait_all_done();
      bit got = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge iClk);
         #1;
         if (done_cnt >= n_pushed) begin
            got = 1'b1;
            break;
         end
      end
      check("done_timeout", 32'(got), 32'd1);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_ready"}, 32'(oReady), 32'd1);
      check({tag, "_rngclr"}, 32'(rng_clr), 32'd1);
      check({tag, "_rngen"}, 32'(rng_en), 32'd0);
      check({tag, "_bit"}, 32'(oBit), 32'd0);
      check({tag, "_valid"}, 32'(oBitValid), 32'd0);
      check({tag, "_done"}, 32'(oDone), 32'd0);
      check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      iRstN  = 1'b0;
      iEn    = 1'b1;
      iClr   = 1'b0;
      iValid = 1'b0;
      iData  = '0;
      #12;
      check_idle_outputs("reset");
`ifdef USADD_ONES_CNT_EN
      check("reset_oOnes", 32'(ones), 32'd0);
`endif
      @(negedge iClk);
      iRstN = 1'b1;
      repeat (2) @(posedge iClk);
      #1;

      // Half scale: first Sobol words 0,128,192,64 give bits 1,0,0,1.
      send(8'h80, 9'd128, N);
      wait_all_done();
      check("first_bits_0x80", 32'(first_bits), 32'b1001);

      // Zero then full code back to back, one IDLE cycle in between.
      send(8'h00, 9'd0, N);
      post(8'hFF, 9'd255, N);
      wait_accept();
      check("b2b_idle_gap", 32'(last_gap), 32'd1);
      wait_all_done();

      // Stall 10 cycles at bit 100.
      send(8'h40, 9'd64, N + 10);
      wait_bits(100);
      iEn = 1'b0;
      repeat (10) begin
         @(posedge iClk);
         #1;
         check("stall_no_valid", 32'(oBitValid), 32'd0);
         check("stall_rngen", 32'(rng_en), 32'd0);
      end
      iEn = 1'b1;
      wait_all_done();

      // Abort at bit 50; no done for the aborted stream.
      iData  = 8'hC3;
      iValid = 1'b1;
      wait_accept();
      wait_bits(50);
      iClr = 1'b1;
      @(posedge iClk);
      #1;
      iClr = 1'b0;
      check_idle_outputs("clr");
`ifdef USADD_ONES_CNT_EN
      check("clr_oOnes", 32'(ones), 32'd0);
`endif
      send(8'h10, 9'd16, N);
      wait_all_done();

      // Operand offered during RUN waits for the first IDLE cycle.
      send(8'h20, 9'd32, N);
      wait_bits(20);
      post(8'h55, 9'd85, N);
      check("run_not_ready", 32'(oReady), 32'd0);
      wait_accept();
      check("run_offer_gap", 32'(last_gap), 32'd1);
      wait_all_done();

      // Asynchronous reset at bit 40.
      iData  = 8'hA5;
      iValid = 1'b1;
      wait_accept();
      wait_bits(40);
      iRstN = 1'b0;
      #1;
      check_idle_outputs("midrun_reset");
      @(posedge iClk);
      @(negedge iClk);
      iRstN = 1'b1;
      @(posedge iClk);
      #1;
      check("ready_after_reset", 32'(oReady), 32'd1);

      // Stream after reset is still correct.
      send(8'h01, 9'd1, N);
      wait_all_done();

      repeat (4) @(posedge iClk);
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
